// File: rtl/ysyx_22040175_imem_resp.sv
// Instruction-memory responder: single outstanding fetch, LATENCY-cycle response, word load port.
// Optional IMEM_ADDR_CHECK_EN: flag misaligned/out-of-range fetches as ebreak and drop out-of-range loads.
module ysyx_22040175_imem_resp #(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                LATENCY   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              busy
);
    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam bit          ONE_CYCLE = (LATENCY == 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    logic [31:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic [ADDR_W-1:0] rd_addr, rd_off, ld_off;
    logic [IDX_W-1:0]  rd_idx, ld_idx;
    logic              rd_bad, ld_ok, accept, do_read;
    logic [31:0]       rd_word;
    logic              unused_addr_bits;

    // In WAIT the word comes from the registered address; otherwise the read
    // happens in the accept cycle straight from req_addr (LATENCY==1 path).
    assign rd_addr = (state_q == S_WAIT) ? addr_q : req_addr;
    assign rd_off  = rd_addr - BASE_ADDR;
    assign ld_off  = load_addr - BASE_ADDR;
    assign rd_idx  = rd_off[IDX_W+1:2];
    assign ld_idx  = ld_off[IDX_W+1:2];
    assign unused_addr_bits = ^{rd_off, ld_off};

`ifdef IMEM_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(4 * DEPTH);
    assign rd_bad = (rd_off[1:0] != 2'b00) || ({1'b0, rd_off} >= SPAN);
    assign ld_ok  = ({1'b0, ld_off} < SPAN);
`else
    assign rd_bad = 1'b0;
    assign ld_ok  = 1'b1;
`endif

    assign rd_word   = rd_bad ? EBREAK : mem[rd_idx];
    assign req_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && resp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        do_read = 1'b0;
        case (state_q)
            // cnt counts the WAIT cycles left including this one; the read
            // happens on the last so resp_valid lands exactly LATENCY after accept.
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    do_read = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: ;
        endcase
        if (accept) begin
            addr_d = req_addr;
            if (ONE_CYCLE) begin
                do_read = 1'b1;
                state_d = S_RESP;
            end else begin
                cnt_d   = CNT_INIT;
                state_d = S_WAIT;
            end
        end
        if (do_read) begin
            data_d = rd_word;
            err_d  = rd_bad;
        end
        valid_d = (state_d == S_RESP);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Memory survives rst; read above is asynchronous so a same-cycle load sees the old word.
    always_ff @(posedge clk) begin
        if (load_en && ld_ok) mem[ld_idx] <= load_data;
    end

    assign resp_valid = valid_q;
    assign resp_data  = data_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_ysyx_22040175_imem_resp.sv
// Directed bench for ysyx_22040175_imem_resp: three instances at LATENCY 1, 3 and 4 sharing stimulus.
module tb_ysyx_22040175_imem_resp;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, resp_ready, load_en;
    logic [31:0] req_addr, load_addr, load_data;
    logic        rr [3];
    logic        rv [3];
    logic        re [3];
    logic        bz [3];
    logic [31:0] rd [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_22040175_imem_resp #(.LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[0]), .req_addr(req_addr),
        .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_data(rd[0]), .resp_err(re[0]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(bz[0]));
    ysyx_22040175_imem_resp #(.LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[1]), .req_addr(req_addr),
        .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_data(rd[1]), .resp_err(re[1]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(bz[1]));
    ysyx_22040175_imem_resp #(.LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[2]), .req_addr(req_addr),
        .resp_valid(rv[2]), .resp_ready(resp_ready), .resp_data(rd[2]), .resp_err(re[2]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(bz[2]));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        resp_ready = 1'b0;
        load_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Single LATENCY=1 fetch, one stall cycle, then drain.
    task automatic fetch1(input string nm, input logic [31:0] a, input logic [31:0] d, input logic e);
        req_valid = 1'b1;
        req_addr = a;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk({nm, ".valid"}, 32'(rv[0]), 32'd1);
        chk({nm, ".data"}, rd[0], d);
        chk({nm, ".err"}, 32'(re[0]), 32'(e));
        resp_ready = 1'b1;
        @(negedge clk);
        chk({nm, ".drain_valid"}, 32'(rv[0]), 32'd0);
        chk({nm, ".drain_busy"}, 32'(bz[0]), 32'd0);
    endtask

    vec_t vt [7];
    logic [31:0] s_addr [3];
    logic [31:0] s_exp [3];
    logic saw;

    initial begin
        req_addr = 32'd0;
        load_addr = 32'd0;
        load_data = 32'd0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset.req_ready%0d", i), 32'(rr[i]), 32'd1);
            chk($sformatf("reset.resp_valid%0d", i), 32'(rv[i]), 32'd0);
            chk($sformatf("reset.resp_data%0d", i), rd[i], 32'd0);
            chk($sformatf("reset.resp_err%0d", i), 32'(re[i]), 32'd0);
            chk($sformatf("reset.busy%0d", i), 32'(bz[i]), 32'd0);
        end

        load_word(32'h8000_0000, 32'h0000_0413);
        load_word(32'h8000_0004, 32'h0010_0093);
        load_word(32'h8000_0008, 32'h0020_0113);
        load_word(32'h8000_0FFC, 32'hDEAD_BEEF);

        vt[0] = '{32'h8000_0000, 32'h0000_0413, 1'b0};
        vt[1] = '{32'h8000_0004, 32'h0010_0093, 1'b0};
        vt[2] = '{32'h8000_0008, 32'h0020_0113, 1'b0};
        vt[3] = '{32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0};
`ifdef IMEM_ADDR_CHECK_EN
        vt[4] = '{32'h8000_1000, 32'h0010_0073, 1'b1};
        vt[5] = '{32'h8000_0002, 32'h0010_0073, 1'b1};
        vt[6] = '{32'h7FFF_FFFC, 32'h0010_0073, 1'b1};
`else
        vt[4] = '{32'h8000_1000, 32'h0000_0413, 1'b0};
        vt[5] = '{32'h8000_0006, 32'h0010_0093, 1'b0};
        vt[6] = '{32'h7FFF_FFFC, 32'hDEAD_BEEF, 1'b0};
`endif
        for (int i = 0; i < 7; i++) fetch1($sformatf("vec%0d", i), vt[i].addr, vt[i].data, vt[i].err);

        // LATENCY=3 timing
        do_reset();
        req_valid = 1'b1;
        req_addr = 32'h8000_0004;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("lat3.n1.req_ready", 32'(rr[1]), 32'd0);
        chk("lat3.n1.resp_valid", 32'(rv[1]), 32'd0);
        chk("lat3.n1.busy", 32'(bz[1]), 32'd1);
        @(negedge clk);
        chk("lat3.n2.req_ready", 32'(rr[1]), 32'd0);
        chk("lat3.n2.resp_valid", 32'(rv[1]), 32'd0);
        @(negedge clk);
        chk("lat3.n3.resp_valid", 32'(rv[1]), 32'd1);
        chk("lat3.n3.resp_data", rd[1], 32'h0010_0093);
        @(negedge clk);
        chk("lat3.done.resp_valid", 32'(rv[1]), 32'd0);
        chk("lat3.done.busy", 32'(bz[1]), 32'd0);

        // Backpressure: response held, new request waits for resp_ready
        do_reset();
        req_valid = 1'b1;
        req_addr = 32'h8000_0008;
        resp_ready = 1'b0;
        @(negedge clk);
        req_addr = 32'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d.valid", i), 32'(rv[0]), 32'd1);
            chk($sformatf("stall%0d.data", i), rd[0], 32'h0020_0113);
            chk($sformatf("stall%0d.req_ready", i), 32'(rr[0]), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        chk("stall.release.req_ready", 32'(rr[0]), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("stall.next.valid", 32'(rv[0]), 32'd1);
        chk("stall.next.data", rd[0], 32'h0000_0413);
        @(negedge clk);
        chk("stall.idle.valid", 32'(rv[0]), 32'd0);

        // Streaming at one word per cycle
        do_reset();
        s_addr[0] = 32'h8000_0000; s_exp[0] = 32'h0000_0413;
        s_addr[1] = 32'h8000_0004; s_exp[1] = 32'h0010_0093;
        s_addr[2] = 32'h8000_0008; s_exp[2] = 32'h0020_0113;
        resp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = s_addr[i];
            @(negedge clk);
            chk($sformatf("stream%0d.valid", i), 32'(rv[0]), 32'd1);
            chk($sformatf("stream%0d.data", i), rd[0], s_exp[i]);
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("stream.end.valid", 32'(rv[0]), 32'd0);

        // Load and fetch of the same word in one cycle returns the old word
        req_valid = 1'b1;
        req_addr = 32'h8000_0008;
        resp_ready = 1'b0;
        load_en = 1'b1;
        load_addr = 32'h8000_0008;
        load_data = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        load_en = 1'b0;
        chk("rbw.old.data", rd[0], 32'h0020_0113);
        resp_ready = 1'b1;
        @(negedge clk);
        fetch1("rbw.new", 32'h8000_0008, 32'hCAFE_F00D, 1'b0);

        // Reset during WAIT drops the request
        do_reset();
        req_valid = 1'b1;
        req_addr = 32'h8000_0000;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstwait.busy", 32'(bz[2]), 32'd1);
        chk("rstwait.req_ready", 32'(rr[2]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstwait.after.req_ready", 32'(rr[2]), 32'd1);
        chk("rstwait.after.busy", 32'(bz[2]), 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rv[2]) saw = 1'b1;
            @(negedge clk);
        end
        chk("rstwait.no_resp", 32'(saw), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
